// File: rtl/lsram2axi_bridge_mp.sv
// Multi-port SRAM-like to AXI3 bridge: round-robin over NUM_PORTS masters, AXI ID = port index.
// Latency: addr_ok same cycle as req, AR/AW/W valid 1 cycle later; R/B -> data_ok combinational.
// Backpressure: requests are held off via addr_ok (eligibility); AXI valids hold until ready.
module lsram2axi_bridge_mp #(
  parameter int NUM_PORTS  = 2,
  parameter int MAX_RD_OUT = 2
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  // SRAM-like ports
  input  logic [NUM_PORTS-1:0]      req,
  input  logic [NUM_PORTS-1:0]      wr,
  input  logic [2*NUM_PORTS-1:0]    size,
  input  logic [32*NUM_PORTS-1:0]   addr,
  input  logic [32*NUM_PORTS-1:0]   wdata,
  output logic [NUM_PORTS-1:0]      addr_ok,
  output logic [NUM_PORTS-1:0]      data_ok,
  output logic [32*NUM_PORTS-1:0]   rdata_o,
  // AR
  output logic [3:0]                arid,
  output logic [31:0]               araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic [1:0]                arlock,
  output logic [3:0]                arcache,
  output logic [2:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,
  // R
  input  logic [3:0]                rid,
  input  logic [31:0]               rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  // AW
  output logic [3:0]                awid,
  output logic [31:0]               awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic [1:0]                awlock,
  output logic [3:0]                awcache,
  output logic [2:0]                awprot,
  output logic                      awvalid,
  input  logic                      awready,
  // W (axi_wdata avoids clashing with the per-port wdata input)
  output logic [3:0]                wid,
  output logic [31:0]               axi_wdata,
  output logic [3:0]                wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  // B
  input  logic [3:0]                bid,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(MAX_RD_OUT + 1);

  logic [CW-1:0]  rd_cnt [NUM_PORTS];
  logic           rdy_en;
  logic           wr_busy;
  logic [PW-1:0]  wr_port;
  logic [29:0]    wr_word;
  logic [PW-1:0]  rr_ptr;

  logic [1:0]     p_size  [NUM_PORTS];
  logic [31:0]    p_addr  [NUM_PORTS];
  logic [31:0]    p_wdata [NUM_PORTS];
  logic [NUM_PORTS-1:0] elig;

  logic           gnt_vld;
  logic [PW-1:0]  gnt_idx;
  logic           gnt_rd;
  logic           gnt_wr;
  logic [31:0]    g_addr;
  logic [1:0]     g_size;
  logic [31:0]    g_wdata;
  logic [3:0]     g_strb;
  logic           r_fire;
  logic           b_fire;

  logic unused_inputs;
  assign unused_inputs = ^{rresp, rlast, bresp};

  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wlast   = 1'b1;

  // Grants stay off until the first cycle after reset release, same as rready/bready.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      p_size[p]  = size[2*p +: 2];
      p_addr[p]  = addr[32*p +: 32];
      p_wdata[p] = wdata[32*p +: 32];
      if (wr[p]) begin
        elig[p] = req[p] && rdy_en && (rd_cnt[p] == '0) && !wr_busy;
      end else begin
        elig[p] = req[p] && rdy_en && (rd_cnt[p] < CW'(MAX_RD_OUT)) && !arvalid &&
                  !(wr_busy && ((wr_port == PW'(p)) || (wr_word == p_addr[p][31:2])));
      end
    end
  end

  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    addr_ok = '0;
    if (gnt_vld) addr_ok[gnt_idx] = 1'b1;
  end

  assign gnt_rd  = gnt_vld && !wr[gnt_idx];
  assign gnt_wr  = gnt_vld &&  wr[gnt_idx];
  assign g_addr  = p_addr[gnt_idx];
  assign g_size  = p_size[gnt_idx];
  assign g_wdata = p_wdata[gnt_idx];

  always_comb begin
    case (g_size)
      2'd0:    g_strb = 4'b0001 << g_addr[1:0];
      2'd1:    g_strb = g_addr[1] ? 4'b1100 : 4'b0011;
      default: g_strb = 4'b1111;
    endcase
  end

  // A read and a B to the same port in one cycle: the read wins, B waits a cycle.
  assign rready  = rdy_en;
  assign bready  = rdy_en && !(rvalid && (rid == bid));
  assign r_fire  = rvalid && rready;
  assign b_fire  = bvalid && bready;
  assign rdata_o = {NUM_PORTS{rdata}};

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      data_ok[p] = (r_fire && (rid == 4'(p))) || (b_fire && (bid == 4'(p)));
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_en <= 1'b0;
      rr_ptr <= '0;
      for (int p = 0; p < NUM_PORTS; p++) rd_cnt[p] <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (gnt_vld) rr_ptr <= (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if ((gnt_rd && (gnt_idx == PW'(p))) && !(r_fire && (rid == 4'(p)))) begin
          rd_cnt[p] <= rd_cnt[p] + 1'b1;
        end else if (!(gnt_rd && (gnt_idx == PW'(p))) && r_fire && (rid == 4'(p)) &&
                     (rd_cnt[p] != '0)) begin
          rd_cnt[p] <= rd_cnt[p] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arvalid <= 1'b0;
      arid    <= '0;
      araddr  <= '0;
      arsize  <= '0;
    end else if (gnt_rd) begin
      arvalid <= 1'b1;
      arid    <= 4'(gnt_idx);
      araddr  <= g_addr;
      arsize  <= {1'b0, g_size};
    end else if (arready) begin
      arvalid <= 1'b0;
    end
  end

  // wr_busy spans AW, W and B; only the B handshake releases it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_busy   <= 1'b0;
      wr_port   <= '0;
      wr_word   <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      awid      <= '0;
      awaddr    <= '0;
      awsize    <= '0;
      wid       <= '0;
      axi_wdata <= '0;
      wstrb     <= '0;
    end else if (gnt_wr) begin
      wr_busy   <= 1'b1;
      wr_port   <= gnt_idx;
      wr_word   <= g_addr[31:2];
      awvalid   <= 1'b1;
      wvalid    <= 1'b1;
      awid      <= 4'(gnt_idx);
      awaddr    <= g_addr;
      awsize    <= {1'b0, g_size};
      wid       <= 4'(gnt_idx);
      axi_wdata <= g_wdata;
      wstrb     <= g_strb;
    end else begin
      if (awready) awvalid <= 1'b0;
      if (wready)  wvalid  <= 1'b0;
      if (b_fire)  wr_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lsram2axi_bridge_mp.sv
// Randomised bench: SRAM-like masters and an AXI slave driven from $urandom, with a
// transaction-level reference model predicting grants, AXI payloads and responses.
module tb_lsram2axi_bridge_mp;
  localparam int NP   = 2;
  localparam int MAXO = 2;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] dat;
  } rent_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [NP-1:0] req, wr, addr_ok, data_ok;
  logic [2*NP-1:0] size;
  logic [32*NP-1:0] addr, wdata, rdata_o;
  logic [3:0] arid, awid, wid, rid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, awaddr, axi_wdata, rdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, arlock, awburst, awlock, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic wlast, wvalid, wready, bvalid, bready;

  lsram2axi_bridge_mp #(.NUM_PORTS(NP), .MAX_RD_OUT(MAXO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata_o(rdata_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .axi_wdata(axi_wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Master-side pending requests
  bit          m_req [NP];
  bit          m_wr  [NP];
  logic [1:0]  m_size [NP];
  logic [31:0] m_addr [NP];
  logic [31:0] m_wdata [NP];
  // Reference model of bridge obligations
  int          rd_out [NP];
  int          rrp;
  bit          ar_busy;
  logic [3:0]  e_arid;
  logic [31:0] e_araddr;
  logic [2:0]  e_arsize;
  bit          wr_busy, aw_pend, w_pend, b_out;
  int          wr_port;
  logic [31:0] wr_addr, e_awaddr, e_wdata;
  logic [2:0]  e_awsize;
  logic [3:0]  e_wstrb;
  // Slave-side read data awaiting return
  rent_t       rq[$];
  int          r_j;
  bit          quiet;

  task automatic clear_model();
    for (int p = 0; p < NP; p++) begin
      m_req[p] = 0;
      rd_out[p] = 0;
    end
    rrp = 0; ar_busy = 0; wr_busy = 0; aw_pend = 0; w_pend = 0; b_out = 0;
    rq.delete();
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      if (!m_req[p] && !quiet && $urandom_range(0, 2) != 0) begin
        m_req[p]   = 1;
        m_wr[p]    = ($urandom_range(0, 3) == 0);
        m_size[p]  = 2'($urandom_range(0, 2));
        m_addr[p]  = 32'h100 + 4 * $urandom_range(0, 3);
        if (m_size[p] == 0) m_addr[p] = m_addr[p] + $urandom_range(0, 3);
        if (m_size[p] == 1) m_addr[p] = m_addr[p] + 2 * $urandom_range(0, 1);
        m_wdata[p] = $urandom;
      end
      req[p]            = m_req[p];
      wr[p]             = m_wr[p];
      size[2*p +: 2]    = m_size[p];
      addr[32*p +: 32]  = m_addr[p];
      wdata[32*p +: 32] = m_wdata[p];
    end
    arready = ($urandom_range(0, 3) != 0);
    awready = 1'($urandom_range(0, 1));
    wready  = 1'($urandom_range(0, 1));
    rresp   = 2'($urandom_range(0, 3));
    rlast   = 1'b1;
    if (rq.size() > 0 && $urandom_range(0, 1) == 1) begin
      int k;
      k = $urandom_range(0, rq.size() - 1);
      r_j = k;
      for (int j = k; j >= 0; j--) if (rq[j].id == rq[k].id) r_j = j;
      rvalid = 1'b1;
      rid    = rq[r_j].id;
      rdata  = rq[r_j].dat;
    end else begin
      rvalid = 1'b0;
      rid    = 4'($urandom_range(0, NP - 1));
      rdata  = $urandom;
    end
    if (!b_out && wr_busy && !aw_pend && !w_pend && $urandom_range(0, 1) == 1) begin
      b_out = 1;
      bid   = 4'(wr_port);
    end
    bvalid = b_out;
    bresp  = 2'($urandom_range(0, 3));
  endtask

  task automatic step();
    logic [NP-1:0] e_ok, e_dok;
    int g, p;
    bit el, brdy, bfire;
    e_ok = '0;
    g = -1;
    for (int k = 0; k < NP; k++) begin
      p = (rrp + k) % NP;
      if (!m_req[p]) el = 0;
      else if (m_wr[p]) el = (rd_out[p] == 0) && !wr_busy;
      else el = (rd_out[p] < MAXO) && !ar_busy &&
                !(wr_busy && (wr_port == p || wr_addr / 4 == m_addr[p] / 4));
      if (el && g < 0) g = p;
    end
    if (g >= 0) e_ok[g] = 1'b1;
    brdy  = !(rvalid && rid == bid);
    bfire = bvalid && brdy;
    e_dok = '0;
    if (rvalid) e_dok[rid] = 1'b1;
    if (bfire) e_dok[bid] = 1'b1;

    check("addr_ok", addr_ok, e_ok);
    check("rready", rready, 1);
    check("bready", bready, brdy);
    check("data_ok", data_ok, e_dok);
    if (rvalid) check("rdata_o", rdata_o[32*rid +: 32], rdata);
    check("arvalid", arvalid, ar_busy);
    if (ar_busy) begin
      check("arid", arid, e_arid);
      check("araddr", araddr, e_araddr);
      check("arsize", arsize, e_arsize);
    end
    check("awvalid", awvalid, aw_pend);
    if (aw_pend) begin
      check("awid", awid, wr_port);
      check("awaddr", awaddr, e_awaddr);
      check("awsize", awsize, e_awsize);
    end
    check("wvalid", wvalid, w_pend);
    if (w_pend) begin
      check("wid", wid, wr_port);
      check("wdata", axi_wdata, e_wdata);
      check("wstrb", wstrb, e_wstrb);
    end

    if (rvalid) begin
      rd_out[rid]--;
      rq.delete(r_j);
    end
    if (ar_busy && arready) begin
      rq.push_back('{id: e_arid, dat: $urandom});
      ar_busy = 0;
    end
    if (aw_pend && awready) aw_pend = 0;
    if (w_pend && wready) w_pend = 0;
    if (bfire) begin
      wr_busy = 0;
      b_out = 0;
    end
    if (g >= 0) begin
      m_req[g] = 0;
      rrp = (g + 1) % NP;
      if (m_wr[g]) begin
        wr_busy = 1; aw_pend = 1; w_pend = 1;
        wr_port  = g;
        wr_addr  = m_addr[g];
        e_awaddr = m_addr[g];
        e_awsize = {1'b0, m_size[g]};
        e_wdata  = m_wdata[g];
        case (m_size[g])
          2'd0:    e_wstrb = 4'(1 << (m_addr[g] % 4));
          2'd1:    e_wstrb = (m_addr[g] % 4 >= 2) ? 4'hC : 4'h3;
          default: e_wstrb = 4'hF;
        endcase
      end else begin
        rd_out[g]++;
        ar_busy  = 1;
        e_arid   = 4'(g);
        e_araddr = m_addr[g];
        e_arsize = {1'b0, m_size[g]};
      end
    end
  endtask

  task automatic do_reset(input bit mid);
    @(negedge aclk);
    if (mid) check("arvalid_before_reset", arvalid, 1);
    aresetn = 1'b0;
    rvalid = 1'b0;
    bvalid = 1'b0;
    #1;
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_addr_ok", addr_ok, 0);
    check("rst_data_ok", data_ok, 0);
    clear_model();
    req = '0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  initial begin
    bit did_mid;
    did_mid = 0;
    quiet = 0;
    clear_model();
    for (int p = 0; p < NP; p++) begin
      m_wr[p] = 0; m_size[p] = 2'd2; m_addr[p] = 32'h100; m_wdata[p] = '0;
    end
    req = '1; wr = '0; size = '0; addr = '0; wdata = '0;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rid = 0; bid = 0; rdata = 0; rresp = 0; rlast = 1; bresp = 0;
    do_reset(0);
    @(negedge aclk);
    #1;
    check("const_arlen", arlen, 0);
    check("const_arburst", arburst, 1);
    check("const_arlock_cache_prot", {arlock, arcache, arprot}, 0);
    check("const_awlen", awlen, 0);
    check("const_awburst", awburst, 1);
    check("const_awlock_cache_prot", {awlock, awcache, awprot}, 0);
    check("const_wlast", wlast, 1);
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cyc >= 3000 && !did_mid && ar_busy) begin
        do_reset(1);
        did_mid = 1;
      end else begin
        quiet = (cyc >= 5700);
        @(negedge aclk);
        drive();
        #1;
        step();
      end
    end
    check("drain_arvalid", arvalid, 0);
    check("drain_awvalid", awvalid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
